// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//
// Shares the single data-memory (Dm) port between the pipeline MEM stage
// and one external requester, such as a debug or loader bridge. The pipeline
// has priority. The external side gets one-cycle grants (state S_EXT) when
// the pipeline is idle. Consecutive external requests can be served back to
// back while the pipeline stays idle.
//
// Optional feature, enabled by defining DM_ARB_FAIR_EN:
//   When the macro is defined, a starvation counter tracks how many cycles
//   the external side has been blocked. After STARVE_LIMIT consecutive
//   blocked cycles, a grant is forced and the pipeline is stalled for that
//   one cycle. When the macro is not defined, priority is strictly fixed:
//   p_stall is constant 0 and the external side can starve.
//
// Parameters:
//   CNT_W         width of the starvation counter
//   STARVE_LIMIT  blocked cycles before a forced grant (1 .. 2**CNT_W-1)
//
// Ports:
//   clk, reset                     clock (rising edge); synchronous,
//                                  active-high reset
//   p_req/p_we/p_type/p_sign/      pipeline MEM-stage access
//   p_addr/p_wdata/p_pc
//   p_rdata, p_stall               load data and freeze request to pipeline
//   x_req/x_we/x_type/x_sign/      external access, held until x_ready
//   x_addr/x_wdata
//   x_ready                        external access performed this cycle
//   x_rvalid, x_rdata              registered external read result (pulse)
//   dm_we/dm_type/dm_sign/         drive to the Dm instance
//   dm_addr/dm_wdata/dm_pc
//   dm_rdata                       combinational read data from Dm
module dm_port_arbiter #(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [1:0]  p_type,
    input  logic        p_sign,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [31:0] p_pc,
    output logic [31:0] p_rdata,
    output logic        p_stall,
    input  logic        x_req,
    input  logic        x_we,
    input  logic [1:0]  x_type,
    input  logic        x_sign,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    output logic        x_ready,
    output logic        x_rvalid,
    output logic [31:0] x_rdata,
    output logic        dm_we,
    output logic [1:0]  dm_type,
    output logic        dm_sign,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);

    typedef enum logic {
        S_PIPE = 1'b0,
        S_EXT  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   starve;
    logic   ext_busy;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_limit
        $error("dm_port_arbiter: STARVE_LIMIT out of range for CNT_W");
    end

    // A grant cycle only performs an access while the requester still holds
    // x_req. This matters because the requester drops x_req in the cycle
    // after being served. Without this qualification, the back-to-back hold
    // in S_EXT would issue a spurious access.
    assign ext_busy = (state == S_EXT) && x_req;

`ifdef DM_ARB_FAIR_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;

    assign starve = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_PIPE) begin
            // Entering S_EXT clears the counter, and so does a cycle with no
            // pending external request. A blocked external request
            // increments the counter, saturating at the limit.
            if (state_nxt == S_EXT || !x_req) begin
                cnt <= '0;
            end else if (p_req && !starve) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_PIPE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dm_we     = p_req & p_we & ~reset;
        dm_type   = p_type;
        dm_sign   = p_sign;
        dm_addr   = p_addr;
        dm_wdata  = p_wdata;
        dm_pc     = p_pc;
        x_ready   = 1'b0;
        p_stall   = 1'b0;

        case (state)
            S_PIPE: begin
                if (x_req && (!p_req || starve)) begin
                    state_nxt = S_EXT;
                end
            end
            S_EXT: begin
                if (ext_busy) begin
                    dm_we    = x_we & ~reset;
                    dm_type  = x_type;
                    dm_sign  = x_sign;
                    dm_addr  = x_addr;
                    dm_wdata = x_wdata;
                    dm_pc    = 32'h0;
                    x_ready  = ~reset;
`ifdef DM_ARB_FAIR_EN
                    p_stall  = p_req;
`endif
                end
                state_nxt = (x_req && !p_req) ? S_EXT : S_PIPE;
            end
            default: state_nxt = S_PIPE;
        endcase
    end

    assign p_rdata = dm_rdata;

    // External read result: captured at the edge that ends the grant cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_rvalid <= 1'b0;
            x_rdata  <= 32'h0;
        end else begin
            x_rvalid <= ext_busy && !x_we;
            if (ext_busy && !x_we) begin
                x_rdata <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

`ifdef DM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req, p_we, p_sign;
    logic [1:0]  p_type;
    logic [31:0] p_addr, p_wdata, p_pc, p_rdata;
    logic        p_stall;
    logic        x_req, x_we, x_sign;
    logic [1:0]  x_type;
    logic [31:0] x_addr, x_wdata;
    logic        x_ready, x_rvalid;
    logic [31:0] x_rdata;
    logic        dm_we, dm_sign;
    logic [1:0]  dm_type;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ready_seen = 0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
    } rdy_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rv_t;

    rdy_t rdy_q[$];
    rv_t  rv_q[$];

    dm_port_arbiter #(.CNT_W(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_we(p_we), .p_type(p_type), .p_sign(p_sign),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_pc(p_pc),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .x_req(x_req), .x_we(x_we), .x_type(x_type), .x_sign(x_sign),
        .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ready(x_ready), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .dm_we(dm_we), .dm_type(dm_type), .dm_sign(dm_sign),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word-addressed data memory model
    assign dm_rdata = mem[dm_addr[9:2]];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every grant and every read result the DUT presents
    // must match the oldest entry queued by the stimulus.
    always @(negedge clk) begin
        if (x_ready) begin
            ready_seen++;
            if (rdy_q.size() == 0) begin
                check("ready_unexpected", 32'(x_ready), 32'h0);
            end else begin
                rdy_t e;
                e = rdy_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("ready_addr", dm_addr, e.addr);
                check("ready_we", 32'(dm_we), 32'(e.we));
            end
        end
        if (x_rvalid) begin
            if (rv_q.size() == 0) begin
                check("rvalid_unexpected", 32'(x_rvalid), 32'h0);
            end else begin
                rv_t r;
                r = rv_q.pop_front();
                check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                check("rdata", x_rdata, r.data);
            end
        end
    end

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (x_ready) seen = 1'b1;
        end
        if (!seen) check("ready_timeout", 32'h0, 32'h1);
    endtask

    task automatic x_single(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rexp);
        @(posedge clk); #1;
        x_req = 1'b1; x_we = we; x_addr = addr; x_wdata = wdata;
        rdy_q.push_back('{cyc: cyc + 1, addr: addr, we: we});
        if (!we) rv_q.push_back('{cyc: cyc + 2, data: rexp});
        wait_ready();
        @(posedge clk); #1;
        x_req = 1'b0; x_we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int rs0;
        bit drop;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h0C] = 32'hA0A0_0001;   // 0x30
        mem[8'h0D] = 32'hB0B0_0002;   // 0x34
        mem[8'h0E] = 32'hC0C0_0003;   // 0x38
        mem[8'h18] = 32'h0BAD_F00D;   // 0x60
        mem[8'h08] = 32'h5A5A_A5A5;   // 0x20

        reset = 1'b1;
        p_req = 0; p_we = 0; p_type = 2'b10; p_sign = 0;
        p_addr = 0; p_wdata = 0; p_pc = 0;
        x_req = 0; x_we = 0; x_type = 2'b10; x_sign = 0;
        x_addr = 0; x_wdata = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x_ready", 32'(x_ready), 32'h0);
        check("rst_p_stall", 32'(p_stall), 32'h0);
        check("rst_x_rvalid", 32'(x_rvalid), 32'h0);
        check("rst_x_rdata", x_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // External write then read with the pipeline idle
        x_single(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
        x_single(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        check("mem_0x10", mem[8'h04], 32'hDEAD_BEEF);

        // Three back-to-back external reads
        @(posedge clk); #1;
        x_req = 1'b1; x_we = 1'b0; x_addr = 32'h30;
        rdy_q.push_back('{cyc: cyc + 1, addr: 32'h30, we: 1'b0});
        rdy_q.push_back('{cyc: cyc + 2, addr: 32'h34, we: 1'b0});
        rdy_q.push_back('{cyc: cyc + 3, addr: 32'h38, we: 1'b0});
        rv_q.push_back('{cyc: cyc + 2, data: 32'hA0A0_0001});
        rv_q.push_back('{cyc: cyc + 3, data: 32'hB0B0_0002});
        rv_q.push_back('{cyc: cyc + 4, data: 32'hC0C0_0003});
        wait_ready();
        @(posedge clk); #1; x_addr = 32'h34;
        wait_ready();
        @(posedge clk); #1; x_addr = 32'h38;
        wait_ready();
        @(posedge clk); #1; x_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Continuous pipeline stores against a continuous external write
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h40; p_wdata = 32'h1111_1111;
        p_pc = 32'h0040_0200;
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h50; x_wdata = 32'h2222_2222;
        t0 = cyc;
        rs0 = ready_seen;
        if (FAIR) rdy_q.push_back('{cyc: t0 + 9, addr: 32'h50, we: 1'b1});
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("fair_p_stall_c%0d", i), 32'(p_stall),
                  32'(FAIR && i == 9));
            check($sformatf("fair_dm_addr_c%0d", i), dm_addr,
                  (FAIR && i == 9) ? 32'h50 : 32'h40);
            drop = x_ready;
            @(posedge clk); #1;
            if (drop) begin x_req = 1'b0; x_we = 1'b0; end
        end
        check("fair_ready_count", 32'(ready_seen - rs0), FAIR ? 32'h1 : 32'h0);
        check("fair_mem_0x50", mem[8'h14], FAIR ? 32'h2222_2222 : 32'h0);
        check("fair_mem_0x40", mem[8'h10], 32'h1111_1111);
        p_req = 1'b0; p_we = 1'b0; x_req = 1'b0; x_we = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset in the grant cycle of an external write
        x_req = 1'b1; x_we = 1'b1; x_addr = 32'h60; x_wdata = 32'h1234_5678;
        p_pc = 32'hCAFE_0000;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_ext_dm_we", 32'(dm_we), 32'h0);
        check("rst_ext_dm_pc", dm_pc, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; x_we = 1'b0;
        // A request held straight after reset must wait one cycle (S_PIPE).
        rdy_q.push_back('{cyc: cyc + 1, addr: 32'h60, we: 1'b0});
        rv_q.push_back('{cyc: cyc + 2, data: 32'h0BAD_F00D});
        @(negedge clk);
        check("rst_ext_rvalid", 32'(x_rvalid), 32'h0);
        check("rst_ext_x_rdata", x_rdata, 32'h0);
        wait_ready();
        @(posedge clk); #1; x_req = 1'b0;
        @(posedge clk); #1;
        check("rst_ext_mem_0x60", mem[8'h18], 32'h0BAD_F00D);

        // Pipeline load with no external request
        @(posedge clk); #1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h20; p_pc = 32'h0040_0100;
        p_type = 2'b01; p_sign = 1'b1;
        @(negedge clk);
        check("pload_p_rdata", p_rdata, 32'h5A5A_A5A5);
        check("pload_dm_pc", dm_pc, 32'h0040_0100);
        check("pload_dm_addr", dm_addr, 32'h20);
        check("pload_dm_we", 32'(dm_we), 32'h0);
        check("pload_dm_type", 32'(dm_type), 32'h1);
        check("pload_p_stall", 32'(p_stall), 32'h0);
        @(posedge clk); #1;
        p_req = 1'b0;
        repeat (3) @(posedge clk);

        check("ready_queue_left", 32'(rdy_q.size()), 32'h0);
        check("rvalid_queue_left", 32'(rv_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
